// File: rtl/mem_dump_reader.sv
// mem_dump_reader: debug readback engine. Freezes the CPU, reads a contiguous
// range of words through a dedicated synchronous read port and streams each
// word with its address over a valid/ready interface, one word at a time.
module mem_dump_reader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   output logic              busy,
   output logic              done,
   output logic              hold_cpu,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr
);

   typedef enum logic [2:0] {IDLE, READ, WAIT, PRESENT, DONE} state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_W:0]   REM_ONE  = 1;
   localparam logic [ADDR_W:0]   REM_ZERO = 0;
   // last WAIT count; the read data is valid in that cycle
   localparam logic [2:0]        LAT_LAST = 3'(RD_LAT - 1);

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic [2:0]        lat_cnt;

   // the CPU stays frozen for the whole dump including the DONE cycle
   assign hold_cpu = busy;

   // control FSM with registered outputs; one outstanding read at most
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         lat_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
                  if (word_count != REM_ZERO) begin
                     addr      <= base_addr;
                     remaining <= word_count;
                     mem_addr  <= base_addr;
                     mem_rd_en <= 1'b1;
                     state     <= READ;
                  end else begin
                     // empty dump: straight to DONE without touching memory
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            READ: begin
               mem_rd_en <= 1'b0;
               lat_cnt   <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               if (lat_cnt == LAT_LAST) begin
                  out_data  <= mem_rdata;
                  out_addr  <= addr;
                  out_valid <= 1'b1;
                  state     <= PRESENT;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            PRESENT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  addr      <= addr + ADDR_ONE;
                  remaining <= remaining - REM_ONE;
                  if (remaining == REM_ONE) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     mem_addr  <= addr + ADDR_ONE;
                     mem_rd_en <= 1'b1;
                     state     <= READ;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
